// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream (length, little-endian words, XOR
// checksum) and writes it word by word into the instruction RAM, holding the
// core in reset for the whole session.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH     = 9,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clka,
  input  logic                  rsta_n,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [31:0]           dina,
  output logic                  wea,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int unsigned MAX_WORDS = 1 << ADDR_WIDTH;
  localparam int unsigned TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0]  ERR_LEN   = 2'b01;
  localparam logic [1:0]  ERR_TMO   = 2'b10;
  localparam logic [1:0]  ERR_CSUM  = 2'b11;
  localparam logic [ADDR_WIDTH:0] WL_ONE = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t              state;
  logic [7:0]          len_lo;
  logic [7:0]          csum;
  logic [ADDR_WIDTH:0] n_words;
  logic [23:0]         word_buf;
  logic [1:0]          byte_idx;
  logic [TW-1:0]       tcnt;

  logic                accept;
  logic                rx_state;
  logic [15:0]         len_c;
  logic                len_ok;
  logic                tmo;
  logic [ADDR_WIDTH:0] wl_next;

  // Byte-receiving states open the handshake; decoded from the state register only
  assign rx_state = (state == S_LEN0) || (state == S_LEN1) ||
                    (state == S_DATA) || (state == S_CSUM);
  assign rx_ready = rx_state;
  assign accept   = rx_valid && rx_ready;
  assign len_c    = {rx_data, len_lo};
  assign len_ok   = (len_c != 16'd0) && (32'(len_c) <= MAX_WORDS);
  assign tmo      = (32'(tcnt) == (TIMEOUT_CYCLES - 32'd1));
  assign wl_next  = words_loaded + WL_ONE;

  // Session FSM with all status and RAM-port outputs registered
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state        <= S_IDLE;
      len_lo       <= 8'd0;
      csum         <= 8'd0;
      n_words      <= '0;
      word_buf     <= 24'd0;
      byte_idx     <= 2'd0;
      tcnt         <= '0;
      addra        <= '0;
      dina         <= 32'd0;
      wea          <= 1'b0;
      cpu_hold     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_code     <= 2'b00;
      words_loaded <= '0;
    end else begin
      wea <= 1'b0;

      // Idle-gap watchdog; an accept in the same cycle takes priority
      if (rx_state && !accept) begin
        if (tmo) begin
          state    <= S_ERR;
          err      <= 1'b1;
          err_code <= ERR_TMO;
          busy     <= 1'b0;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
      end

      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state        <= S_LEN0;
            busy         <= 1'b1;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            err_code     <= 2'b00;
            words_loaded <= '0;
            tcnt         <= '0;
          end
        end
        S_LEN0: begin
          if (accept) begin
            len_lo <= rx_data;
            csum   <= rx_data;
            tcnt   <= '0;
            state  <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (accept) begin
            csum <= csum ^ rx_data;
            tcnt <= '0;
            if (len_ok) begin
              n_words  <= (ADDR_WIDTH + 1)'(len_c);
              byte_idx <= 2'd0;
              state    <= S_DATA;
            end else begin
              state    <= S_ERR;
              err      <= 1'b1;
              err_code <= ERR_LEN;
              busy     <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            csum     <= csum ^ rx_data;
            tcnt     <= '0;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              dina  <= {rx_data, word_buf};
              addra <= words_loaded[ADDR_WIDTH-1:0];
              wea   <= 1'b1;
              state <= S_WRITE;
            end else begin
              word_buf <= {rx_data, word_buf[23:8]};
            end
          end
        end
        S_WRITE: begin
          words_loaded <= wl_next;
          state        <= (wl_next < n_words) ? S_DATA : S_CSUM;
        end
        S_CSUM: begin
          if (accept) begin
            tcnt <= '0;
            busy <= 1'b0;
            if (rx_data == csum) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state    <= S_ERR;
              err      <= 1'b1;
              err_code <= ERR_CSUM;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: a frame model predicts RAM writes
// and the final session status; a monitor pops and compares as the DUT reports.
module tb_imem_loader;

  localparam int AW  = 9;
  localparam int TMO = 16;

  typedef struct packed {
    logic        done;
    logic        err;
    logic [1:0]  code;
    logic        hold;
    logic        busy;
    logic [9:0]  words;
    logic [31:0] cyc;
  } end_t;

  logic          clk = 1'b0;
  logic          rsta_n;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [AW-1:0] addra;
  logic [31:0]   dina;
  logic          wea;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    err_code;
  logic [AW:0]   words_loaded;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  bit prev_end = 1'b0;

  logic [31:0] words [0:511];
  logic [40:0] exp_wr [$];
  end_t        exp_end [$];

  imem_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clka(clk), .rsta_n(rsta_n), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .addra(addra), .dina(dina),
    .wea(wea), .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Edge counter used to check latencies
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: pops expected writes and session outcomes as the DUT presents them
  always @(negedge clk) begin
    logic [40:0] e;
    end_t        ee;
    end_t        a;
    if (rsta_n) begin
      if (wea) begin
        if (exp_wr.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_write: addra %0d dina %h, none expected", addra, dina);
        end else begin
          e = exp_wr.pop_front();
          check("write_addr_data", {addra, dina}, e);
          check("write_latency", 32'(cyc), 32'(last_acc_cyc));
        end
      end
      if ((done || err) && !prev_end) begin
        a.done = done; a.err = err; a.code = err_code; a.hold = cpu_hold;
        a.busy = busy; a.words = words_loaded; a.cyc = 32'(cyc);
        if (exp_end.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_end: status %h, none expected", a);
        end else begin
          ee = exp_end.pop_front();
          check("end_status", a, ee);
        end
      end
      prev_end = done || err;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int guard;
    bit r;
    if ($urandom_range(0, 3) == 0) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    guard    = 0;
    forever begin
      @(negedge clk);
      r = rx_ready;
      @(posedge clk);
      #1;
      if (r) break;
      guard++;
      if (guard > 40) begin
        n_cmp++; n_fail++;
        $display("FAIL byte_accept: rx_ready stayed 0 for %0d cycles, required 1", guard);
        break;
      end
    end
    last_acc_cyc = cyc;
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_state", {rx_ready, busy, cpu_hold, done, err, err_code, words_loaded},
          {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 10'd0});
  endtask

  // stall >= 0: send only that many data bytes then go quiet (or reset if do_reset)
  task automatic run_frame(input logic [15:0] nf, input bit bad_cs, input int stall,
                           input bit mid_start, input bit do_reset);
    logic [7:0] q [$];
    logic [7:0] cs;
    logic [31:0] wv;
    bit   ok;
    int   n_send;
    int   nfull;
    int   g;
    end_t e;
    ok = (nf >= 16'd1) && (nf <= 16'd512);
    q.push_back(nf[7:0]);
    q.push_back(nf[15:8]);
    if (ok)
      for (int w = 0; w < int'(nf); w++) begin
        wv = words[w];
        for (int k = 0; k < 4; k++) q.push_back(wv[8*k +: 8]);
      end
    cs = 8'd0;
    foreach (q[i]) cs = cs ^ q[i];
    q.push_back(cs ^ {7'd0, bad_cs});
    if (!ok)            n_send = 2;
    else if (stall >= 0) n_send = 2 + stall;
    else                n_send = q.size();
    nfull = !ok ? 0 : ((stall >= 0) ? stall / 4 : int'(nf));
    for (int w = 0; w < nfull; w++) exp_wr.push_back({9'(w), words[w]});

    do_start();
    for (int i = 0; i < n_send; i++) begin
      send_byte(q[i]);
      if (mid_start && i == 6) begin
        rx_valid = 1'b0;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
      end
    end
    rx_valid = 1'b0;

    if (do_reset) begin
      #2;
      rsta_n = 1'b0;
      #1;
      check("async_reset", {addra, dina, wea, cpu_hold, busy, done, err, err_code,
                            words_loaded, rx_ready}, 64'd0);
      check("pre_reset_writes", 64'(exp_wr.size()), 64'd0);
      exp_wr.delete();
      exp_end.delete();
      prev_end = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rsta_n = 1'b1;
      return;
    end

    e.done  = ok && (stall < 0) && !bad_cs;
    e.err   = !e.done;
    e.code  = !ok ? 2'b01 : (stall >= 0) ? 2'b10 : bad_cs ? 2'b11 : 2'b00;
    e.hold  = !e.done;
    e.busy  = 1'b0;
    e.words = 10'(nfull);
    e.cyc   = 32'(last_acc_cyc + ((stall >= 0) ? TMO : 0));
    exp_end.push_back(e);

    g = 0;
    while (busy && g < TMO + 100) begin
      @(posedge clk); #1;
      g++;
    end
    check("session_ended", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check("writes_drained", 64'(exp_wr.size()), 64'd0);
    check("end_reported", 64'(exp_end.size()), 64'd0);
    exp_wr.delete();
    exp_end.delete();
  endtask

  task automatic fill_words();
    for (int i = 0; i < 512; i++) words[i] = $urandom;
  endtask

  initial begin
    rsta_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {addra, dina, wea, cpu_hold, busy, done, err, err_code,
                            words_loaded, rx_ready}, 64'd0);
    rsta_n = 1'b1;

    fill_words();
    words[0] = 32'h0000_0013;
    words[1] = 32'h0010_0093;
    run_frame(16'd2, 1'b0, -1, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      fill_words();
      run_frame(16'($urandom_range(1, 8)), 1'b0, -1, (i == 2), 1'b0);
    end

    fill_words();
    run_frame(16'd512, 1'b0, -1, 1'b0, 1'b0);

    run_frame(16'h0000, 1'b0, -1, 1'b0, 1'b0);
    run_frame(16'h0201, 1'b0, -1, 1'b0, 1'b0);
    run_frame(16'h8001, 1'b0, -1, 1'b0, 1'b0);

    fill_words();
    run_frame(16'd5, 1'b1, -1, 1'b0, 1'b0);

    run_frame(16'd2, 1'b0, 3, 1'b0, 1'b0);

    fill_words();
    run_frame(16'd4, 1'b0, 6, 1'b0, 1'b1);
    fill_words();
    run_frame(16'd3, 1'b0, -1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
